// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX-stage operand forwarding selects and load-use stall detection
module fwd_hazard_unit #(
    parameter int g_REG_ADDR_W = 5
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_n,
    input  logic                    i_Id_Valid,
    input  logic [g_REG_ADDR_W-1:0] i_Id_Rs1,
    input  logic [g_REG_ADDR_W-1:0] i_Id_Rs2,
    input  logic                    i_Id_Uses_Rs1,
    input  logic                    i_Id_Uses_Rs2,
    input  logic [g_REG_ADDR_W-1:0] i_Id_Rd,
    input  logic                    i_Id_Reg_Write,
    input  logic                    i_Id_Mem_Read,
    input  logic                    i_Flush,
    output logic                    o_Stall,
    output logic                    o_Ex_Valid,
    output logic [1:0]              o_Fwd_A_Sel,
    output logic [1:0]              o_Fwd_B_Sel
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;
    localparam logic [1:0] SEL_RET = 2'b11;

    // Stage tags. The load flag only matters while the load sits in EX
    // (that is the only place a load-use hazard is detected), so it is not
    // carried past EX.
    logic                    ex_valid;
    logic [g_REG_ADDR_W-1:0] ex_rd;
    logic                    ex_reg_write;
    logic                    ex_mem_read;

    logic                    mem_valid;
    logic [g_REG_ADDR_W-1:0] mem_rd;
    logic                    mem_reg_write;

    logic                    wb_valid;
    logic [g_REG_ADDR_W-1:0] wb_rd;
    logic                    wb_reg_write;

    logic [1:0]              fwd_a_q;
    logic [1:0]              fwd_b_q;

    // Per-stage match results for each ID source
    logic ex_hit_rs1,  ex_hit_rs2;
    logic mem_hit_rs1, mem_hit_rs2;
    logic wb_hit_rs1,  wb_hit_rs2;
    logic load_use;
    logic ex_bubble;
    logic [1:0] fwd_a_next;
    logic [1:0] fwd_b_next;

    // A stage forwards only if it holds a live, writing, non-x0 producer of the source
    function automatic logic fwd_match(
        input logic                    valid,
        input logic                    reg_write,
        input logic [g_REG_ADDR_W-1:0] rd,
        input logic [g_REG_ADDR_W-1:0] rs
    );
        return valid && reg_write && (rd != '0) && (rd == rs);
    endfunction

    // Youngest producer wins; stages are named by where they sit now, and
    // each one will have advanced one stage by the time the consumer is in EX
    function automatic logic [1:0] pick_sel(
        input logic uses,
        input logic ex_hit,
        input logic mem_hit,
        input logic wb_hit
    );
        if (!uses)        return SEL_RF;
        else if (ex_hit)  return SEL_MEM;
        else if (mem_hit) return SEL_WB;
        else if (wb_hit)  return SEL_RET;
        else              return SEL_RF;
    endfunction

    // Source matching, load-use detection and next selects
    always_comb begin
        ex_hit_rs1  = fwd_match(ex_valid,  ex_reg_write,  ex_rd,  i_Id_Rs1);
        ex_hit_rs2  = fwd_match(ex_valid,  ex_reg_write,  ex_rd,  i_Id_Rs2);
        mem_hit_rs1 = fwd_match(mem_valid, mem_reg_write, mem_rd, i_Id_Rs1);
        mem_hit_rs2 = fwd_match(mem_valid, mem_reg_write, mem_rd, i_Id_Rs2);
        wb_hit_rs1  = fwd_match(wb_valid,  wb_reg_write,  wb_rd,  i_Id_Rs1);
        wb_hit_rs2  = fwd_match(wb_valid,  wb_reg_write,  wb_rd,  i_Id_Rs2);

        load_use = i_Id_Valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                   ((i_Id_Uses_Rs1 && (ex_rd == i_Id_Rs1)) ||
                    (i_Id_Uses_Rs2 && (ex_rd == i_Id_Rs2)));

        // Flush kills the ID instruction, so it also cancels any stall on it
        o_Stall   = i_Rst_n && !i_Flush && load_use;
        ex_bubble = i_Flush || load_use;

        fwd_a_next = pick_sel(i_Id_Uses_Rs1, ex_hit_rs1, mem_hit_rs1, wb_hit_rs1);
        fwd_b_next = pick_sel(i_Id_Uses_Rs2, ex_hit_rs2, mem_hit_rs2, wb_hit_rs2);
    end

    // Tag pipeline and registered selects; EX takes a bubble on stall or flush
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            ex_valid      <= 1'b0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_valid     <= 1'b0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            fwd_a_q       <= SEL_RF;
            fwd_b_q       <= SEL_RF;
        end else begin
            mem_valid     <= ex_valid;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            wb_valid      <= mem_valid;
            wb_rd         <= mem_rd;
            wb_reg_write  <= mem_reg_write;
            if (ex_bubble) begin
                ex_valid     <= 1'b0;
                ex_rd        <= '0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
                fwd_a_q      <= SEL_RF;
                fwd_b_q      <= SEL_RF;
            end else begin
                ex_valid     <= i_Id_Valid;
                ex_rd        <= i_Id_Rd;
                ex_reg_write <= i_Id_Valid && i_Id_Reg_Write;
                ex_mem_read  <= i_Id_Valid && i_Id_Mem_Read;
                fwd_a_q      <= i_Id_Valid ? fwd_a_next : SEL_RF;
                fwd_b_q      <= i_Id_Valid ? fwd_b_next : SEL_RF;
            end
        end
    end

    assign o_Ex_Valid  = ex_valid;
    assign o_Fwd_A_Sel = fwd_a_q;
    assign o_Fwd_B_Sel = fwd_b_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - scoreboard testbench for fwd_hazard_unit
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_uses_rs1, id_uses_rs2;
    logic       id_reg_write, id_mem_read;
    logic       flush;
    logic       stall;
    logic       ex_valid;
    logic [1:0] fwd_a, fwd_b;

    int checks = 0;
    int errors = 0;

    // Each entry: {stall before edge, ex_valid, fwd_a, fwd_b after edge}
    logic [5:0] exp_q[$];
    logic [5:0] obs_q[$];
    string      name_q[$];

    always #5 clk = ~clk;

    fwd_hazard_unit #(.g_REG_ADDR_W(5)) dut (
        .i_Clk          (clk),
        .i_Rst_n        (rst_n),
        .i_Id_Valid     (id_valid),
        .i_Id_Rs1       (id_rs1),
        .i_Id_Rs2       (id_rs2),
        .i_Id_Uses_Rs1  (id_uses_rs1),
        .i_Id_Uses_Rs2  (id_uses_rs2),
        .i_Id_Rd        (id_rd),
        .i_Id_Reg_Write (id_reg_write),
        .i_Id_Mem_Read  (id_mem_read),
        .i_Flush        (flush),
        .o_Stall        (stall),
        .o_Ex_Valid     (ex_valid),
        .o_Fwd_A_Sel    (fwd_a),
        .o_Fwd_B_Sel    (fwd_b)
    );

    // Drive one ID slot for one cycle, record expectation and observation
    task automatic cyc(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl,
                       input string nm, input logic [5:0] e);
        logic s;
        id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
        exp_q.push_back(e);
        name_q.push_back(nm);
        #1;
        s = stall;
        @(posedge clk);
        #1;
        obs_q.push_back({s, ex_valid, fwd_a, fwd_b});
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, "drain", 6'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cyc(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, "rst_hold0", 6'b0_0_00_00);
        cyc(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, "rst_hold1", 6'b0_0_00_00);
        rst_n = 1'b1;
        cyc(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, "rst_first", 6'b0_1_00_00);
        nops(3);
        while (exp_q.size() > 0) begin
            logic [5:0] e, o; string nm;
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset/%s got %b required %b", nm, o, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        cyc(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, "b2b_i1", 6'b0_1_00_00);
        cyc(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, "b2b_i2", 6'b0_1_01_00);
        nops(3);
        while (exp_q.size() > 0) begin
            logic [5:0] e, o; string nm;
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back/%s got %b required %b", nm, o, e);
            end
        end
    endtask

    task automatic test_distance;
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, "d2_i1", 6'b0_1_00_00);
        nops(1);
        cyc(1'b1, 5'd1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, "d2_i3", 6'b0_1_00_10);
        nops(3);
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, "d3_i1", 6'b0_1_00_00);
        nops(2);
        cyc(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, "d3_i4", 6'b0_1_11_00);
        nops(3);
        while (exp_q.size() > 0) begin
            logic [5:0] e, o; string nm;
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL distance/%s got %b required %b", nm, o, e);
            end
        end
    endtask

    task automatic test_load_use;
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, "lu_lw",    6'b0_1_00_00);
        cyc(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, "lu_stall", 6'b1_0_00_00);
        cyc(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, "lu_add",   6'b0_1_10_00);
        nops(3);
        while (exp_q.size() > 0) begin
            logic [5:0] e, o; string nm;
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL load_use/%s got %b required %b", nm, o, e);
            end
        end
    endtask

    task automatic test_x0_priority;
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, "x0_i1", 6'b0_1_00_00);
        cyc(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1,  1'b1, 1'b0, 1'b0, "x0_i2", 6'b0_1_00_00);
        nops(3);
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, "pr_i0", 6'b0_1_00_00);
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6,  1'b1, 1'b0, 1'b0, "pr_i1", 6'b0_1_00_00);
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6,  1'b1, 1'b0, 1'b0, "pr_i2", 6'b0_1_00_00);
        cyc(1'b1, 5'd6, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, "pr_i3", 6'b0_1_01_11);
        cyc(1'b1, 5'd6, 1'b0, 5'd6, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, "pr_unused", 6'b0_1_00_00);
        nops(3);
        while (exp_q.size() > 0) begin
            logic [5:0] e, o; string nm;
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL x0_priority/%s got %b required %b", nm, o, e);
            end
        end
    endtask

    task automatic test_flush;
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, "fl_lw",  6'b0_1_00_00);
        cyc(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, "fl_add", 6'b0_0_00_00);
        nops(3);
        while (exp_q.size() > 0) begin
            logic [5:0] e, o; string nm;
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL flush/%s got %b required %b", nm, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_stall;
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, "rm_lw",    6'b0_1_00_00);
        rst_n = 1'b0;
        cyc(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, "rm_rst",   6'b0_0_00_00);
        rst_n = 1'b1;
        cyc(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, "rm_after", 6'b0_1_00_00);
        nops(3);
        while (exp_q.size() > 0) begin
            logic [5:0] e, o; string nm;
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid_stall/%s got %b required %b", nm, o, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_reg_write = 1'b0;
        id_mem_read = 1'b0; flush = 1'b0;
        test_reset();
        test_back_to_back();
        test_distance();
        test_load_use();
        test_x0_priority();
        test_flush();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter g_REG_ADDR_W, default 5, SHALL set the register-address width.
REQ-003 The block SHALL provide the following ports:
- i_Clk  in  1  rising-edge clock
- i_Rst_n  in  1  synchronous active-low reset
- i_Id_Valid  in  1  ID-stage instruction valid
- i_Id_Rs1, i_Id_Rs2  in  g_REG_ADDR_W  ID source registers
- i_Id_Uses_Rs1, i_Id_Uses_Rs2  in  1  source actually read
- i_Id_Rd  in  g_REG_ADDR_W  ID destination register
- i_Id_Reg_Write  in  1  ID instruction writes Rd
- i_Id_Mem_Read  in  1  ID instruction is a load
- i_Flush  in  1  taken branch: kill ID instruction
- o_Stall  out  1  hold PC and IF/ID register
- o_Ex_Valid  out  1  EX-stage instruction valid
- o_Fwd_A_Sel, o_Fwd_B_Sel  out  2  operand-mux selects for the EX operand 4:1 muxes

Function
REQ-004 The block SHALL keep registered tags (valid, rd, reg_write, mem_read) for the EX, MEM and WB stages.
REQ-005 On every non-reset edge, tags SHALL advance as follows:
- EX tags move to MEM.
- MEM tags move to WB.
- ID inputs load into EX, unless stall or flush applies.
REQ-006 A stage SHALL be a forwarding source only when all of the following hold: valid=1, reg_write=1, rd!=0, and rd equals the source register.
REQ-007 Select encoding SHALL be:
- 00: register file
- 01: EX/MEM result (the producer now in MEM)
- 10: MEM/WB result (the producer now in WB)
- 11: WB-retired result (the producer that left WB on the previous edge)
REQ-008 The selects SHALL be computed when ID loads into EX, and SHALL be registered, so that they are valid in the same cycle as o_Ex_Valid.
REQ-009 Select priority SHALL be youngest first:
- 01 if the current EX tag matches;
- else 10 if the current MEM tag matches;
- else 11 if the current WB tag matches;
- else 00.
REQ-010 A source with i_Id_Uses_Rsx=0 SHALL yield select 00.
REQ-011 Load-use hazard: o_Stall SHALL be combinational 1 when all of the following hold: i_Id_Valid=1, EX valid=1, EX mem_read=1, EX rd!=0, and EX rd matches a used ID source.
REQ-012 During a stall, EX SHALL load a bubble (valid=0, reg_write=0, mem_read=0, selects 00) and the ID inputs SHALL be held by upstream.
REQ-013 A load-use stall SHALL last exactly one cycle. On the following edge the held instruction enters EX with select 10 for the load-dependent operand.
REQ-014 i_Flush=1 SHALL load a bubble into EX and force o_Stall=0; flush has priority over stall.
REQ-015 A bubble (i_Id_Valid=0) SHALL propagate as valid=0 and SHALL never match as a forwarding source.
REQ-016 Rs1 and Rs2 SHALL be evaluated independently; both selects may be nonzero and may differ.
REQ-017 No combinational path SHALL exist from the ID inputs to o_Fwd_A_Sel, o_Fwd_B_Sel or o_Ex_Valid; o_Stall is the only combinational output.

Reset
REQ-018 With i_Rst_n=0 at a rising edge, all stage tags SHALL clear to zero, and o_Ex_Valid=0, o_Fwd_A_Sel=00, o_Fwd_B_Sel=00.
REQ-019 o_Stall SHALL be 0 whenever i_Rst_n=0 and in the first cycle after reset release.
REQ-020 Reset asserted mid-stall SHALL cancel the stall and discard all in-flight tags; no forwarding from pre-reset instructions SHALL occur after release.

Verification
REQ-021 The bench SHALL cover back-to-back ALU forwarding:
- Stimulus: I1 rd=3 reg_write=1, then I2 rs1=3 rs2=4.
- Response: I2 in EX shows o_Fwd_A_Sel=01 and o_Fwd_B_Sel=00.
REQ-022 The bench SHALL cover forwarding at distances 2 and 3:
- Stimulus: I1 rd=5, then a nop, then I3 rs2=5; separately, I1 rd=5, then two nops, then I4 rs1=5.
- Response: I3 shows B sel=10; I4 shows A sel=11.
REQ-023 The bench SHALL cover load-use:
- Stimulus: LW rd=7, then ADD rs1=7.
- Response: o_Stall=1 for exactly 1 cycle; EX bubble with o_Ex_Valid=0; then ADD in EX with A sel=10.
REQ-024 The bench SHALL cover the x0 case and youngest-wins priority:
- Stimulus: I1 rd=0, then I2 rs1=0; separately, I1 rd=6, then I2 rd=6, then I3 rs1=6.
- Response: I2 A sel=00; I3 A sel=01.
REQ-025 The bench SHALL cover flush over stall:
- Stimulus: LW rd=2 in EX while ID rs1=2, with i_Flush=1.
- Response: o_Stall=0; next cycle o_Ex_Valid=0.
REQ-026 The bench SHALL cover reset mid-operation:
- Stimulus: assert i_Rst_n=0 during a load-use stall, then release and apply ID rs1=7.
- Response: o_Stall=0 and o_Fwd_A_Sel=00.
